// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Instruction fetch/sequencer feeding the CPU instruction input
// Loadable program memory, PC stepping with a fixed per-instruction hold window.
module instr_fetch #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter int                     HOLD_CYCLES = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = {INSTR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [PC_BITS-1:0]     prog_len,
  input  logic                   start,
  input  logic                   halt_req,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [PC_BITS-1:0]     plen_q, plen_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                   valid_q, valid_d;
  logic                   halt_pending_q, halt_pending_d;
  logic                   mem_we;
  logic                   halt_set;
  logic [PC_BITS-1:0]     pc_next;

  // Program memory is deliberately outside the reset domain so it survives rst.
  logic [INSTR_WIDTH-1:0] mem_q [2**PC_BITS];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    pc_d           = pc_q;
    plen_d         = plen_q;
    hold_cnt_d     = hold_cnt_q;
    valid_d        = 1'b0;
    halt_pending_d = halt_pending_q;
    mem_we         = 1'b0;
    halt_set       = halt_pending_q | halt_req;
    pc_next        = pc_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        // A write and a start in the same cycle: the write wins.
        if (load_en) begin
          mem_we = 1'b1;
        end else if (start) begin
          state_d        = RUN;
          pc_d           = '0;
          instr_d        = mem_q[0];
          valid_d        = 1'b1;
          hold_cnt_d     = '0;
          plen_d         = prog_len;
          halt_pending_d = 1'b0;
        end
      end
      RUN: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d     = hold_cnt_q + 1'b1;
          halt_pending_d = halt_set;
        end else if (halt_set || (pc_q == plen_q)) begin
          state_d        = DONE;
          instr_d        = NOP_INSTR;
          halt_pending_d = 1'b0;
        end else begin
          pc_d       = pc_next;
          instr_d    = mem_q[pc_next];
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      instr_q        <= NOP_INSTR;
      pc_q           <= '0;
      plen_q         <= '0;
      hold_cnt_q     <= '0;
      valid_q        <= 1'b0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      pc_q           <= pc_d;
      plen_q         <= plen_d;
      hold_cnt_q     <= hold_cnt_d;
      valid_q        <= valid_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch/sequencer stage that sits directly upstream of the simple CPU and drives its 20-bit instruction input.
- Holds a loadable program memory and steps a program counter through it.
- Presents each instruction stable for a fixed number of cycles so the CPU's control unit can complete it.
- Outputs a NOP when idle or finished, and supports start, halt and reload.

Parameters:
INSTR_WIDTH, 20, instruction width in bits (matches CPU instruction input)
PC_BITS, 5, program counter / program memory address width (32 entries)
HOLD_CYCLES, 4, cycles each instruction is held on the output (legal range 1..16)
NOP_INSTR, 20'h00000, value driven on instruction when not running

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
load_en  in  1  program memory write strobe
load_addr  in  PC_BITS  program memory write address
load_data  in  INSTR_WIDTH  program memory write data
prog_len  in  PC_BITS  index of last instruction to execute; sampled on start
start  in  1  begin execution from address 0
halt_req  in  1  stop after the current instruction's hold window
instruction  out  INSTR_WIDTH  instruction to CPU (registered)
pc  out  PC_BITS  address of instruction currently presented
instr_valid  out  1  one-cycle pulse on the first cycle a new instruction is presented
busy  out  1  high while in RUN
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, also mid-run):
  - state=IDLE, instruction=NOP_INSTR, pc=0, instr_valid=0, busy=0, done=0.
  - hold counter=0, halt_pending=0, latched prog_len=0.
  - Program memory contents are not cleared by reset.
- States: IDLE, RUN, DONE. Outputs are registered; busy=(state==RUN), done=(state==DONE).
- Program memory writes: in IDLE or DONE, load_en=1 writes mem[load_addr]=load_data at the clock edge. load_en is ignored in RUN.
- IDLE/DONE with start=1 and load_en=0, at edge E:
  - State goes to RUN; pc=0; instruction=mem[0]; instr_valid=1; hold_cnt=0; prog_len latched.
  - Latency: one edge from start sampled to first instruction.
- IDLE/DONE with start=1 and load_en=1: the write wins; start is ignored that cycle.
- RUN, each edge:
  - If hold_cnt < HOLD_CYCLES-1: hold_cnt++, instr_valid=0, instruction unchanged.
  - Else, if halt_pending=1 or pc==latched prog_len: state=DONE, instruction=NOP_INSTR, instr_valid=0, halt_pending=0.
  - Else: pc++, instruction=mem[pc+1], instr_valid=1, hold_cnt=0.
- Hold window: every executed instruction is presented exactly HOLD_CYCLES cycles. A program of N=prog_len+1 instructions occupies N*HOLD_CYCLES cycles in RUN.
- halt_req:
  - In RUN it sets a sticky halt_pending; the current instruction completes its full window, then DONE.
  - halt_req on the final cycle of a window is honoured at that same edge.
  - halt_req in IDLE/DONE is ignored.
- start while in RUN is ignored. prog_len changes after start have no effect.
- HOLD_CYCLES=1: new instruction every cycle; instr_valid stays high throughout RUN.
- No wrap-around: prog_len=2^PC_BITS-1 runs pc 0..31 and then enters DONE; pc never wraps to 0 while in RUN.
- In DONE, pc keeps the last executed address. A new start reruns from 0.
- Memory read is synchronous and the output is registered; no combinational path from inputs to instruction.

Test Plan:
1. HOLD=4: load mem[0..2]=20'h11111,20'h22222,20'h33333, prog_len=2, pulse start -> after the next edge instruction=20'h11111 for 4 cycles, then 20'h22222 for 4, then 20'h33333 for 4; instr_valid pulses 3 times, 4 cycles apart; then done=1, busy=0, instruction=NOP, pc=2.
2. Same program; assert halt_req for one cycle during the 2nd cycle of mem[1]'s window -> mem[1] is held its full 4 cycles, then DONE with pc=1; mem[2] is never presented.
3. Pull rst low mid-window of mem[1] -> instruction=NOP, pc=0, busy=0 immediately, without waiting for a clock; after release the state is IDLE and memory still holds 20'h11111 at address 0.
4. In IDLE, load_en=1 (addr 0, data 20'hABCDE) together with start=1 -> state stays IDLE; the next start presents 20'hABCDE.
5. HOLD=1, prog_len=31, mem[i]=i -> instruction increments 0..31 on consecutive cycles with instr_valid constantly high, then DONE; no wrap to 0.
6. In RUN, load_en=1 writing mem[2] -> write ignored; in DONE the same write takes effect and a restart shows the new value at pc=2.
